// File: rtl/e203_ifu_fetch_arb_if.sv
// Handshake bundle between the fetch arbiter, its two requesters (IFU, debug) and the shared memory port.
interface e203_ifu_fetch_arb_if #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic                  ifu_rsp_err;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;

  logic                  dbg_req_valid;
  logic                  dbg_req_ready;
  logic [PC_SIZE-1:0]    dbg_req_addr;
  logic                  dbg_rsp_valid;
  logic                  dbg_rsp_ready;
  logic                  dbg_rsp_err;
  logic [INSTR_SIZE-1:0] dbg_rsp_rdata;

  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [PC_SIZE-1:0]    m_req_addr;
  logic                  m_rsp_valid;
  logic                  m_rsp_ready;
  logic                  m_rsp_err;
  logic [INSTR_SIZE-1:0] m_rsp_rdata;

  // Arbiter side
  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
    input  dbg_req_valid, dbg_req_addr, dbg_rsp_ready,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata,
    output m_req_valid, m_req_addr, m_rsp_ready,
    input  m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_rdata
  );

  // Requester / memory environment side
  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_instr,
    output dbg_req_valid, dbg_req_addr, dbg_rsp_ready,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_err, dbg_rsp_rdata,
    input  m_req_valid, m_req_addr, m_rsp_ready,
    output m_req_ready, m_rsp_valid, m_rsp_err, m_rsp_rdata
  );
endinterface

// File: rtl/e203_ifu_fetch_arb.sv
// Shares one memory port between IFU fetch and debug access, one outstanding transaction,
// with a starvation counter that forces a debug grant after STARVE_MAX consecutive IFU wins.
module e203_ifu_fetch_arb #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  e203_ifu_fetch_arb_if.slave   bus,
  output logic                  arb_busy,
  output logic                  arb_owner_dbg
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_d;

  logic                  can_issue;
  logic                  grant_dbg;
  logic                  grant_ifu;
  logic                  req_hs;
  logic                  rsp_hs;
  logic                  rsp_ready_sel;
  logic [PC_SIZE-1:0]    grant_addr;
  logic [INSTR_SIZE-1:0] rsp_rdata;

  // State, owner and starvation counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  // Arbitration, handshakes, response routing and next state
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    starve_cnt_d  = starve_cnt;
    rsp_ready_sel = 1'b0;
    rsp_hs        = 1'b0;
    can_issue     = 1'b0;
    grant_dbg     = 1'b0;
    grant_ifu     = 1'b0;
    req_hs        = 1'b0;
    grant_addr    = bus.ifu_req_pc;
    rsp_rdata     = bus.m_rsp_rdata;

    if (state_q == WAIT_RSP) begin
      rsp_ready_sel = owner_q ? bus.dbg_rsp_ready : bus.ifu_rsp_ready;
    end
    rsp_hs = (state_q == WAIT_RSP) && bus.m_rsp_valid && rsp_ready_sel;

    // A completing response frees the port in the same cycle for the next grant
    can_issue = (state_q == IDLE) || rsp_hs;
    grant_dbg = bus.dbg_req_valid &&
                (!bus.ifu_req_valid || (starve_cnt == CNT_W'(STARVE_MAX)));
    grant_ifu = bus.ifu_req_valid && !grant_dbg;
    grant_addr = grant_dbg ? bus.dbg_req_addr : bus.ifu_req_pc;
    req_hs    = can_issue && (bus.ifu_req_valid || bus.dbg_req_valid) && bus.m_req_ready;

    if (req_hs) begin
      state_d = WAIT_RSP;
      owner_d = grant_dbg;
    end else if (rsp_hs) begin
      state_d = IDLE;
    end

    // Count only IFU wins that made debug wait; a debug win resets the streak
    if (req_hs && grant_dbg) begin
      starve_cnt_d = '0;
    end else if (req_hs && bus.dbg_req_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt + CNT_W'(1);
    end
  end

  assign bus.m_req_valid   = can_issue && (bus.ifu_req_valid || bus.dbg_req_valid);
  assign bus.m_req_addr    = grant_addr;
  assign bus.ifu_req_ready = can_issue && grant_ifu && bus.m_req_ready;
  assign bus.dbg_req_ready = can_issue && grant_dbg && bus.m_req_ready;

  assign bus.m_rsp_ready   = rsp_ready_sel;
  assign bus.ifu_rsp_valid = (state_q == WAIT_RSP) && bus.m_rsp_valid && !owner_q;
  assign bus.dbg_rsp_valid = (state_q == WAIT_RSP) && bus.m_rsp_valid && owner_q;

  // Payload goes to both sides unqualified; consumers key off their own valid
  assign bus.ifu_rsp_err   = bus.m_rsp_err;
  assign bus.ifu_rsp_instr = rsp_rdata;
  assign bus.dbg_rsp_err   = bus.m_rsp_err;
  assign bus.dbg_rsp_rdata = rsp_rdata;

  assign arb_busy      = (state_q == WAIT_RSP);
  assign arb_owner_dbg = (state_q == WAIT_RSP) && owner_q;

endmodule
